// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: sizes and aligns accesses onto a ready/valid data bus,
// sign/zero-extends load data and holds the pipeline stalled until the access completes.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic                  op_read,
    input  logic                  op_write,
    input  logic [2:0]            op_funct3,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [31:0]           op_wdata,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_cause,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_we,
    output logic [ADDR_WIDTH-1:0] bus_req_addr,
    output logic [31:0]           bus_req_wdata,
    output logic [3:0]            bus_req_be,
    input  logic                  bus_rsp_valid,
    input  logic [31:0]           bus_rsp_rdata
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic [2:0]              r_f3;
    logic [1:0]              r_a;
    logic [CNT_W-1:0]        r_tmo_cnt;
    logic                    r_req_valid, r_req_we;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic [31:0]             r_req_wdata;
    logic [3:0]              r_req_be;
    logic [31:0]             r_load_data;
    logic                    r_err;
    logic [1:0]              r_cause;

    logic                    w_mem_op, w_illegal, w_misal, w_tmo;
    logic [1:0]              w_a;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata, w_shift, w_ext;

    assign w_a      = op_addr[1:0];
    assign w_mem_op = op_valid & (op_read | op_write);
    assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_illegal = op_read & op_write;
        if (op_write && !(op_funct3 inside {3'b000, 3'b001, 3'b010}))
            w_illegal = 1'b1;
        if (op_read && !(op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            w_illegal = 1'b1;
        w_misal = ((op_funct3[1:0] == 2'b01) && w_a[0]) ||
                  ((op_funct3[1:0] == 2'b10) && (w_a != 2'b00));
        case (op_funct3[1:0])
            2'b00:   begin w_be = 4'b0001 << w_a; w_wdata = {4{op_wdata[7:0]}};  end
            2'b01:   begin w_be = 4'b0011 << w_a; w_wdata = {2{op_wdata[15:0]}}; end
            default: begin w_be = 4'b1111;        w_wdata = op_wdata;            end
        endcase
        if (!op_write)
            w_wdata = 32'd0;
    end

    // Load lane extraction uses the funct3/offset latched at issue.
    always_comb begin
        w_shift = bus_rsp_rdata >> {r_a, 3'b000};
        case (r_f3)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_ext = {24'd0, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_mem_op) w_next = (w_illegal || w_misal) ? S_DONE : S_REQ;
            S_REQ:  if (w_tmo) w_next = S_DONE;
                    else if (bus_req_ready) w_next = S_RESP;
            S_RESP: if (bus_rsp_valid || w_tmo) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f3        <= 3'd0;
            r_a         <= 2'd0;
            r_tmo_cnt   <= '0;
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= 32'd0;
            r_req_be    <= 4'd0;
            r_load_data <= 32'd0;
            r_err       <= 1'b0;
            r_cause     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: if (w_mem_op) begin
                    r_f3 <= op_funct3;
                    r_a  <= w_a;
                    if (w_illegal || w_misal) begin
                        r_load_data <= 32'd0;
                        r_err       <= 1'b1;
                        r_cause     <= w_illegal ? 2'b10 : 2'b01;
                    end else begin
                        r_req_valid <= 1'b1;
                        r_req_we    <= op_write;
                        r_req_addr  <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_req_wdata <= w_wdata;
                        r_req_be    <= w_be;
                        r_tmo_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (w_tmo) begin
                        r_req_valid <= 1'b0;
                        r_load_data <= 32'd0;
                        r_err       <= 1'b1;
                        r_cause     <= 2'b11;
                    end else if (bus_req_ready) begin
                        r_req_valid <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    // A response arriving on the last allowed cycle still completes the access.
                    if (bus_rsp_valid) begin
                        r_load_data <= r_req_we ? 32'd0 : w_ext;
                        r_err       <= 1'b0;
                        r_cause     <= 2'b00;
                    end else if (w_tmo) begin
                        r_load_data <= 32'd0;
                        r_err       <= 1'b1;
                        r_cause     <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall         = rst & w_mem_op & (r_state != S_DONE);
    assign done          = (r_state == S_DONE);
    assign load_data     = r_load_data;
    assign err           = r_err;
    assign err_cause     = r_cause;
    assign bus_req_valid = r_req_valid;
    assign bus_req_we    = r_req_we;
    assign bus_req_addr  = r_req_addr;
    assign bus_req_wdata = r_req_wdata;
    assign bus_req_be    = r_req_be;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: randomized accesses with random bus latency checked every cycle
// against a transaction-level model, plus directed literal checks and reset scenarios.
module tb_load_store_unit;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0, op_read = 1'b0, op_write = 1'b0;
    logic [2:0]  op_funct3 = 3'd0;
    logic [31:0] op_addr = 32'd0, op_wdata = 32'd0;
    logic        stall, done, err;
    logic [31:0] load_data;
    logic [1:0]  err_cause;
    logic        bus_req_valid, bus_req_we;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = 32'd0;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_read(op_read), .op_write(op_write),
        .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .load_data(load_data), .done(done), .err(err), .err_cause(err_cause),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errs = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Expected per-cycle behaviour published by the driver for the compare process.
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_done = 1'b0, exp_reqv = 1'b0, exp_we = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_addr = 32'd0, exp_wd = 32'd0, exp_ld = 32'd0;
    logic [3:0]  exp_be = 4'd0;
    logic [1:0]  exp_cause = 2'd0;

    int          cyc = 0, stall_total = 0, req_total = 0, obs_done_cyc = 0;
    logic [31:0] obs_ld = 32'd0, obs_addr = 32'd0, obs_wd = 32'd0;
    logic [3:0]  obs_be = 4'd0;
    logic        obs_we = 1'b0, obs_err = 1'b0;
    logic [1:0]  obs_cause = 2'd0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("done", 32'(done), 32'(exp_done));
            check("req_valid", 32'(bus_req_valid), 32'(exp_reqv));
            if (stall) stall_total++;
            if (bus_req_valid) req_total++;
            if (exp_reqv) begin
                check("req_addr", bus_req_addr, exp_addr);
                check("req_we", 32'(bus_req_we), 32'(exp_we));
                check("req_be", 32'(bus_req_be), 32'(exp_be));
                check("req_wdata", bus_req_wdata, exp_wd);
                obs_addr = bus_req_addr; obs_we = bus_req_we; obs_be = bus_req_be; obs_wd = bus_req_wdata;
            end
            if (exp_done) begin
                check("load_data", load_data, exp_ld);
                check("err", 32'(err), 32'(exp_err));
                check("err_cause", 32'(err_cause), 32'(exp_cause));
                obs_ld = load_data; obs_err = err; obs_cause = err_cause; obs_done_cyc = cyc;
            end
        end
        cyc++;
    end

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
        int nb = 1 << f3[1:0];
        int ai = int'(a);
        logic [31:0] v = 32'd0;
        for (int j = 0; j < nb; j++) v[8*j +: 8] = rd[8*(ai+j) +: 8];
        if (!f3[2] && nb < 4 && v[8*nb-1])
            for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
        int nb = 1 << f3[1:0];
        int ai = int'(a);
        logic [3:0] b = 4'd0;
        for (int i = 0; i < 4; i++) b[i] = (i >= ai) && (i < ai + nb);
        return b;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic wr, input logic [31:0] wd);
        int nb = 1 << f3[1:0];
        logic [31:0] v = 32'd0;
        if (wr)
            for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % nb) +: 8];
        return v;
    endfunction

    int txn_start = 0;

    // One access: bus accepts after rdly stalled REQ cycles, responds after sdly idle RESP cycles.
    task automatic run_op(input logic rd_, input logic wr_, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdly, input int sdly, input logic [31:0] rdat);
        logic illegal, misal, errp;
        logic [1:0] cause;
        logic [31:0] ld;
        int d, cpl, req_end;
        illegal = (rd_ && wr_) || (wr_ && f3 > 3'd2) || (rd_ && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
        misal   = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        errp    = illegal || misal;
        cpl     = rdly + sdly + 2;
        if (errp) begin d = 1; cause = illegal ? 2'd2 : 2'd1; ld = 32'd0; end
        else if (cpl > TMO) begin d = TMO + 1; cause = 2'd3; ld = 32'd0; end
        else begin d = cpl + 1; cause = 2'd0; ld = wr_ ? 32'd0 : model_load(f3, addr[1:0], rdat); end
        req_end   = errp ? 0 : ((rdly + 1 < TMO) ? rdly + 1 : TMO);
        txn_start = cyc;
        for (int k = 0; k <= d; k++) begin
            op_valid = 1'b1; op_read = rd_; op_write = wr_; op_funct3 = f3; op_addr = addr; op_wdata = wd;
            bus_req_ready = (k >= 1 && k <= req_end) ? (k == rdly + 1) : 1'($urandom);
            bus_rsp_valid = (!errp && k > req_end && k < d) ? (k == cpl) : 1'($urandom);
            bus_rsp_rdata = (!errp && k == cpl) ? rdat : $urandom;
            exp_stall = (k < d); exp_done = (k == d); exp_reqv = (k >= 1 && k <= req_end);
            exp_addr = {addr[31:2], 2'b00}; exp_we = wr_;
            exp_be = model_be(f3, addr[1:0]); exp_wd = model_wd(f3, wr_, wd);
            exp_ld = ld; exp_err = (cause != 2'd0); exp_cause = cause;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            op_valid = 1'($urandom); op_read = 1'b0; op_write = 1'b0;
            op_funct3 = 3'($urandom); op_addr = $urandom; op_wdata = $urandom;
            bus_req_ready = 1'($urandom); bus_rsp_valid = 1'($urandom); bus_rsp_rdata = $urandom;
            exp_stall = 1'b0; exp_done = 1'b0; exp_reqv = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_req_valid"}, 32'(bus_req_valid), 32'd0);
        check({tag, "_req_we"}, 32'(bus_req_we), 32'd0);
        check({tag, "_req_addr"}, bus_req_addr, 32'd0);
        check({tag, "_req_wdata"}, bus_req_wdata, 32'd0);
        check({tag, "_req_be"}, 32'(bus_req_be), 32'd0);
        check({tag, "_load_data"}, load_data, 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_cause"}, 32'(err_cause), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int s0, r0;
        logic rd_, wr_;
        logic [2:0] f3;
        logic [31:0] a;
        int sel;
        // Reset with a load presented: stall must stay low, outputs at reset values.
        op_valid = 1'b1; op_read = 1'b1; op_funct3 = 3'd2;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        op_valid = 1'b0; op_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // LW 0x100, minimum latency.
        s0 = stall_total;
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        check("lw_load_data", obs_ld, 32'hDEADBEEF);
        check("lw_latency", 32'(obs_done_cyc - txn_start), 32'd3);
        check("lw_stall_cycles", 32'(stall_total - s0), 32'd3);
        check("lw_be", 32'(obs_be), 32'hF);
        check("lw_addr", obs_addr, 32'h100);
        // LB / LBU at 0x103.
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 2, 32'h80FF_0000);
        check("lb_load_data", obs_ld, 32'hFFFFFF80);
        check("lb_be", 32'(obs_be), 32'h8);
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF_0000);
        check("lbu_load_data", obs_ld, 32'h00000080);
        // SH at 0x202.
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 2, 0, 32'h5555AAAA);
        check("sh_we", 32'(obs_we), 32'd1);
        check("sh_addr", obs_addr, 32'h200);
        check("sh_be", 32'(obs_be), 32'hC);
        check("sh_wdata", obs_wd, 32'hABCDABCD);
        check("sh_load_data", obs_ld, 32'd0);
        // Misaligned and illegal accesses never touch the bus.
        r0 = req_total;
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
        check("mis_latency", 32'(obs_done_cyc - txn_start), 32'd1);
        check("mis_err", 32'(obs_err), 32'd1);
        check("mis_cause", 32'(obs_cause), 32'd1);
        run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        check("ill_cause", 32'(obs_cause), 32'd2);
        check("err_no_request", 32'(req_total - r0), 32'd0);
        // Response never arrives: timeout after TMO cycles in REQ+RESP.
        run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 100, 32'h0);
        check("tmo_latency", 32'(obs_done_cyc - txn_start), 32'(TMO + 1));
        check("tmo_err", 32'(obs_err), 32'd1);
        check("tmo_cause", 32'(obs_cause), 32'd3);
        idle(1);
        check("tmo_req_dropped", 32'(bus_req_valid), 32'd0);

        // Async reset while waiting in RESP, then a stale response.
        chk_en = 1'b0;
        op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_funct3 = 3'b010; op_addr = 32'h100;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        op_valid = 1'b0; op_read = 1'b0;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_reset_outputs("late_rsp");
        end
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            idle($urandom_range(0, 2));
            sel = $urandom_range(0, 9);
            rd_ = (sel < 6) || (sel == 9);
            wr_ = (sel >= 6);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            a = $urandom;
            if ($urandom_range(0, 1) != 0) a[1:0] = a[1:0] & ~((2'd1 << f3[1:0]) - 2'd1);
            run_op(rd_, wr_, f3, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
        end
        idle(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
